// File: rtl/torpedo_ctrl_pkg.sv
// torpedo_pkg: shared torpedo types (dir_t, tor_slot_t), slot count, speed, sprite size, cooldown and screen limits
package torpedo_pkg;
  localparam int N_TOR = 4;
  localparam logic [9:0] TOR_SPEED = 10'd4;
  localparam logic [9:0] TOR_HALF = 10'd2;
  localparam logic [4:0] COOLDOWN = 5'd16;
  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MAX = 10'd479;
  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
  typedef struct packed {
    logic active;
    logic [9:0] x;
    logic [9:0] y;
    dir_t dir;
  } tor_slot_t;
endpackage

// File: rtl/torpedo_ctrl_if.sv
// torpedo_ctrl_if: game-side bundle (frame_clk, fire, ship_x/y/dir, hit_clr, DrawX/Y in; is_tor, tor_active, tor_x/y out); master drives, slave is torpedo_ctrl
interface torpedo_ctrl_if;
  import torpedo_pkg::*;
  logic frame_clk;
  logic fire;
  logic [9:0] ship_x;
  logic [9:0] ship_y;
  dir_t ship_dir;
  logic [N_TOR-1:0] hit_clr;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [N_TOR-1:0] is_tor;
  logic [N_TOR-1:0] tor_active;
  logic [N_TOR-1:0][9:0] tor_x;
  logic [N_TOR-1:0][9:0] tor_y;
  modport master (
    output frame_clk, fire, ship_x, ship_y, ship_dir, hit_clr, DrawX, DrawY,
    input is_tor, tor_active, tor_x, tor_y
  );
  modport slave (
    input frame_clk, fire, ship_x, ship_y, ship_dir, hit_clr, DrawX, DrawY,
    output is_tor, tor_active, tor_x, tor_y
  );
endinterface

// File: rtl/torpedo_ctrl_tor_slot.sv
// tor_slot: one torpedo slot (Clk, Reset, tick, clr, load, ship pos/dir, draw pos in; active, x, y, pixel hit out); clear > move/retire > load on tick
module tor_slot
  import torpedo_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       clr,
  input  logic       load,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  dir_t       ship_dir,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hit
);
  localparam logic signed [10:0] SP = {1'b0, TOR_SPEED};
  localparam logic signed [10:0] H = {1'b0, TOR_HALF};
  localparam logic signed [10:0] XM = {1'b0, X_MAX};
  localparam logic signed [10:0] YM = {1'b0, Y_MAX};
  tor_slot_t s;
  logic signed [10:0] nx, ny, dx, dy;
  logic off;
  always_comb begin
    nx = $signed({1'b0, s.x}) + (s.dir == RIGHT ? SP : s.dir == LEFT ? -SP : 11'sd0);
    ny = $signed({1'b0, s.y}) + (s.dir == DOWN ? SP : s.dir == UP ? -SP : 11'sd0);
    off = nx < 0 || nx > XM || ny < 0 || ny > YM;
    dx = $signed({1'b0, draw_x}) - $signed({1'b0, s.x});
    dy = $signed({1'b0, draw_y}) - $signed({1'b0, s.y});
    hit = s.active && dx >= -H && dx <= H && dy >= -H && dy <= H;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) s <= '0;
    else if (tick) begin
      if (clr) s.active <= 1'b0;
      else if (s.active) begin
        if (off) s.active <= 1'b0;
        else begin
          s.x <= nx[9:0];
          s.y <= ny[9:0];
        end
      end else if (load) s <= '{active: 1'b1, x: ship_x, y: ship_y, dir: ship_dir};
    end
  assign active = s.active;
  assign x = s.x;
  assign y = s.y;
endmodule

// File: rtl/torpedo_ctrl.sv
// torpedo_ctrl: per-player torpedo manager (Clk, Reset, torpedo_ctrl_if.slave t); frame tick, launch arbitration to lowest free slot, cooldown; TORPEDO_AUTOFIRE_EN enables hold-to-refire
module torpedo_ctrl
  import torpedo_pkg::*;
(
  input logic Clk,
  input logic Reset,
  torpedo_ctrl_if.slave t
);
  logic frame_q, tick, fire_ok, launch;
  logic [4:0] cd_cnt;
  logic [N_TOR-1:0] act, free, target, hit;
  logic [N_TOR-1:0][9:0] xs, ys;
  assign tick = t.frame_clk & ~frame_q;
  assign free = ~act;
  assign target = free & -free;
  assign launch = tick & fire_ok & ~|cd_cnt & |free;
`ifdef TORPEDO_AUTOFIRE_EN
  assign fire_ok = t.fire;
`else
  logic fire_q;
  assign fire_ok = t.fire & ~fire_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) fire_q <= 1'b0;
    else if (tick) fire_q <= t.fire;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      frame_q <= 1'b1;
      cd_cnt <= '0;
    end else begin
      frame_q <= t.frame_clk;
      cd_cnt <= launch ? COOLDOWN : (tick && |cd_cnt) ? cd_cnt - 5'd1 : cd_cnt;
    end
  for (genvar i = 0; i < N_TOR; i++) begin : g_slot
    tor_slot u_slot (
      .Clk(Clk),
      .Reset(Reset),
      .tick(tick),
      .clr(t.hit_clr[i]),
      .load(launch & target[i]),
      .ship_x(t.ship_x),
      .ship_y(t.ship_y),
      .ship_dir(t.ship_dir),
      .draw_x(t.DrawX),
      .draw_y(t.DrawY),
      .active(act[i]),
      .x(xs[i]),
      .y(ys[i]),
      .hit(hit[i])
    );
  end
  assign t.tor_active = act;
  assign t.is_tor = hit;
  assign t.tor_x = xs;
  assign t.tor_y = ys;
endmodule

// File: tb/tb_torpedo_ctrl.sv
// tb_torpedo_ctrl: table-driven check of torpedo_ctrl plus reset and fire-hold sequences
module tb_torpedo_ctrl;
  import torpedo_pkg::*;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  torpedo_ctrl_if t();
  torpedo_ctrl dut (.Clk(Clk), .Reset(Reset), .t(t.slave));
  always #5 Clk = ~Clk;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int nt;
    logic fire;
    logic [9:0] sx, sy;
    logic [1:0] sd;
    logic [3:0] hc;
    int sel;
    logic [9:0] dx, dy;
    logic [3:0] e_act, e_is;
    logic [9:0] e_x, e_y;
    logic [4:0] e_cd;
  } vec_t;
  vec_t v [24];
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic frame(input int n);
    repeat (n) begin
      @(negedge Clk) t.frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      t.frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask
  initial begin
    int lf[$];
    logic [3:0] lm[$];
    int ef[3];
    logic [3:0] em[3];
    int ne;
    logic [3:0] prev, nw;
    v[0]  = '{1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0};
    v[1]  = '{2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0};
    v[2]  = '{1, 1, 100, 200, 1, 4'b0000, 0, 100, 200, 4'b0001, 4'b0001, 100, 200, 16};
    v[3]  = '{1, 0, 100, 200, 1, 4'b0000, 0, 104, 202, 4'b0001, 4'b0001, 104, 200, 15};
    v[4]  = '{1, 0, 100, 200, 1, 4'b0000, 0, 106, 198, 4'b0001, 4'b0001, 108, 200, 14};
    v[5]  = '{0, 0, 100, 200, 1, 4'b0000, 0, 110, 202, 4'b0001, 4'b0001, 108, 200, 14};
    v[6]  = '{0, 0, 100, 200, 1, 4'b0000, 0, 111, 200, 4'b0001, 4'b0000, 108, 200, 14};
    v[7]  = '{0, 0, 100, 200, 1, 4'b0000, 0, 108, 203, 4'b0001, 4'b0000, 108, 200, 14};
    v[8]  = '{1, 0, 100, 200, 1, 4'b0001, 0, 108, 200, 4'b0000, 4'b0000, 108, 200, 13};
    v[9]  = '{13, 0, 100, 200, 1, 4'b0000, 0, 108, 200, 4'b0000, 4'b0000, 108, 200, 0};
    v[10] = '{1, 1, 2, 50, 3, 4'b0000, 0, 0, 48, 4'b0001, 4'b0001, 2, 50, 16};
    v[11] = '{1, 0, 2, 50, 3, 4'b0000, 0, 0, 50, 4'b0000, 4'b0000, 2, 50, 15};
    v[12] = '{15, 0, 2, 50, 3, 4'b0000, 0, 0, 50, 4'b0000, 4'b0000, 2, 50, 0};
    v[13] = '{1, 1, 300, 400, 0, 4'b0000, 0, 300, 400, 4'b0001, 4'b0001, 300, 400, 16};
    v[14] = '{16, 0, 300, 400, 0, 4'b0000, 0, 300, 336, 4'b0001, 4'b0001, 300, 336, 0};
    v[15] = '{1, 1, 300, 400, 0, 4'b0000, 1, 300, 400, 4'b0011, 4'b0010, 300, 400, 16};
    v[16] = '{16, 0, 300, 400, 0, 4'b0000, 0, 0, 0, 4'b0011, 4'b0000, 300, 268, 0};
    v[17] = '{1, 1, 300, 400, 0, 4'b0000, 2, 300, 400, 4'b0111, 4'b0100, 300, 400, 16};
    v[18] = '{16, 0, 300, 400, 0, 4'b0000, 1, 300, 268, 4'b0111, 4'b0010, 300, 268, 0};
    v[19] = '{1, 1, 300, 400, 0, 4'b0000, 3, 300, 400, 4'b1111, 4'b1000, 300, 400, 16};
    v[20] = '{16, 0, 300, 400, 0, 4'b0000, 0, 0, 0, 4'b1111, 4'b0000, 300, 132, 0};
    v[21] = '{1, 1, 300, 400, 0, 4'b0010, 0, 0, 0, 4'b1101, 4'b0000, 300, 128, 0};
    v[22] = '{1, 0, 300, 400, 0, 4'b0000, 0, 0, 0, 4'b1101, 4'b0000, 300, 124, 0};
    v[23] = '{1, 1, 50, 60, 2, 4'b0000, 1, 52, 62, 4'b1111, 4'b0010, 50, 60, 16};
    t.frame_clk = 1'b1;
    t.fire = 1'b1;
    t.ship_x = 10'd10;
    t.ship_y = 10'd10;
    t.ship_dir = UP;
    t.hit_clr = '0;
    t.DrawX = 10'd10;
    t.DrawY = 10'd10;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst active", t.tor_active, 0);
    chk("rst is_tor", t.is_tor, 0);
    chk("rst tor_x0", t.tor_x[0], 0);
    chk("rst tor_y0", t.tor_y[0], 0);
    chk("rst cd_cnt", dut.cd_cnt, 0);
    t.fire = 1'b0;
    t.frame_clk = 1'b0;
    @(negedge Clk);
    foreach (v[i]) begin
      t.fire = v[i].fire;
      t.ship_x = v[i].sx;
      t.ship_y = v[i].sy;
      t.ship_dir = dir_t'(v[i].sd);
      t.hit_clr = v[i].hc;
      frame(v[i].nt);
      t.DrawX = v[i].dx;
      t.DrawY = v[i].dy;
      #1;
      chk($sformatf("v%0d active", i), t.tor_active, v[i].e_act);
      chk($sformatf("v%0d is_tor", i), t.is_tor, v[i].e_is);
      chk($sformatf("v%0d x[%0d]", i, v[i].sel), t.tor_x[v[i].sel], v[i].e_x);
      chk($sformatf("v%0d y[%0d]", i, v[i].sel), t.tor_y[v[i].sel], v[i].e_y);
      chk($sformatf("v%0d cd_cnt", i), dut.cd_cnt, v[i].e_cd);
    end
    t.fire = 1'b0;
    t.hit_clr = '0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("async rst active", t.tor_active, 0);
    chk("async rst cd_cnt", dut.cd_cnt, 0);
    @(negedge Clk) Reset = 1'b0;
    t.fire = 1'b1;
    t.ship_x = 10'd320;
    t.ship_y = 10'd440;
    t.ship_dir = UP;
    prev = '0;
    for (int f = 0; f < 40; f++) begin
      frame(1);
      nw = t.tor_active & ~prev;
      if (nw != 0) begin
        lf.push_back(f);
        lm.push_back(nw);
      end
      prev = t.tor_active;
    end
`ifdef TORPEDO_AUTOFIRE_EN
    ne = 3;
`else
    ne = 1;
`endif
    ef = '{0, 17, 34};
    em = '{4'b0001, 4'b0010, 4'b0100};
    chk("hold launches", lf.size(), ne);
    for (int k = 0; k < ne; k++) begin
      chk($sformatf("hold launch%0d frame", k), lf.size() > k ? lf[k] : -1, ef[k]);
      chk($sformatf("hold launch%0d slot", k), lm.size() > k ? int'(lm[k]) : -1, int'(em[k]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
